// File: rtl/busid_arb_pkg.sv
// Shared constants and FSM state type for the round-robin bus-ID arbiter.
package busid_arb_pkg;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned BUSID_W = 5;
    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/busid_rr_arbiter_if.sv
// Request/grant signal bundle between the requesting channels and the bus-ID arbiter.
interface busid_rr_arbiter_if;
    import busid_arb_pkg::*;

    logic [NUM_CH-1:0]  req_in;
    logic [BUSID_W-1:0] busid_in0;
    logic [BUSID_W-1:0] busid_in1;
    logic [BUSID_W-1:0] busid_in2;
    logic [BUSID_W-1:0] busid_in3;
    logic               done_in;
    logic               buffer_en0;
    logic               buffer_en1;
    logic               buffer_en2;
    logic               buffer_en3;
    logic [BUSID_W-1:0] busid_out;
    logic               busy_out;
    logic               timeout_out;

    modport master (
        output req_in, busid_in0, busid_in1, busid_in2, busid_in3, done_in,
        input  buffer_en0, buffer_en1, buffer_en2, buffer_en3, busid_out, busy_out, timeout_out
    );

    modport slave (
        input  req_in, busid_in0, busid_in1, busid_in2, busid_in3, done_in,
        output buffer_en0, buffer_en1, buffer_en2, buffer_en3, busid_out, busy_out, timeout_out
    );

endinterface

// File: rtl/busid_rr_prio_enc.sv
// Rotating priority encoder: first requester above last_grant, wrapping around.
module busid_rr_prio_enc
    import busid_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   win_idx,
    output logic              win_valid
);

    // Scan farthest-first so the nearest requester after last_grant is the final winner.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (req[CH_W'(int'(last_grant) + k)]) begin
                win_idx   = CH_W'(int'(last_grant) + k);
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/busid_rr_arbiter.sv
// Round-robin bus-ID arbiter: grants one channel at a time and latches its bus ID.
// Define BUSID_ARB_TIMEOUT_EN to add the forced release after TIMEOUT_CYCLES hold cycles.
module busid_rr_arbiter #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned BUSID_W        = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    busid_rr_arbiter_if.slave bus
);
    import busid_arb_pkg::*;

    if (NUM_CH != busid_arb_pkg::NUM_CH || BUSID_W != busid_arb_pkg::BUSID_W ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_err
        $error("busid_rr_arbiter: unsupported parameter set");
    end

    state_e             state_q, state_n;
    logic [CH_W-1:0]    last_q, last_n;
    logic [NUM_CH-1:0]  req_q;
    logic [NUM_CH-1:0]  en_q, en_n;
    logic [BUSID_W-1:0] busid_q, busid_n;
    logic               busy_q, busy_n;
    logic               to_q, to_n;
    logic               to_hit;
    logic [BUSID_W-1:0] busid_arr [NUM_CH];
    logic [CH_W-1:0]    win_idx;
    logic               win_valid;

    assign busid_arr[0] = bus.busid_in0;
    assign busid_arr[1] = bus.busid_in1;
    assign busid_arr[2] = bus.busid_in2;
    assign busid_arr[3] = bus.busid_in3;

    busid_rr_prio_enc u_prio_enc (
        .req        (req_q),
        .last_grant (last_q),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    // Next state; last_q doubles as the index of the active grant.
    always_comb begin
        state_n = state_q;
        last_n  = last_q;
        busid_n = busid_q;
        to_n    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_n = GRANT;
                    last_n  = win_idx;
                    busid_n = busid_arr[win_idx];
                end
            end
            GRANT: state_n = HOLD;
            HOLD: begin
                if (bus.done_in) begin
                    state_n = IDLE;
                end else if (to_hit) begin
                    state_n = IDLE;
                    to_n    = 1'b1;
                end else if (!req_q[last_q]) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        en_n   = (state_n != IDLE) ? (NUM_CH'(1) << last_n) : '0;
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= CH_W'(NUM_CH - 1);
            req_q   <= '0;
            en_q    <= '0;
            busid_q <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            last_q  <= last_n;
            req_q   <= bus.req_in;
            en_q    <= en_n;
            busid_q <= busid_n;
            busy_q  <= busy_n;
            to_q    <= to_n;
        end
    end

`ifdef BUSID_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_n;

    assign to_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts completed HOLD cycles; release happens before the count could wrap.
    always_comb begin
        cnt_n = cnt_q;
        if (state_q == IDLE && state_n == GRANT) begin
            cnt_n = '0;
        end else if (state_q == HOLD && state_n == HOLD) begin
            cnt_n = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_n;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign bus.buffer_en0  = en_q[0];
    assign bus.buffer_en1  = en_q[1];
    assign bus.buffer_en2  = en_q[2];
    assign bus.buffer_en3  = en_q[3];
    assign bus.busid_out   = busid_q;
    assign bus.busy_out    = busy_q;
    assign bus.timeout_out = to_q;

endmodule

// File: tb/tb_busid_rr_arbiter.sv
// Directed table-driven bench for busid_rr_arbiter, with hand sequences for timeout and reset.
module tb_busid_rr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    busid_rr_arbiter_if bus ();

    busid_rr_arbiter #(
        .NUM_CH         (4),
        .BUSID_W        (5),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [4:0] b2;
        logic [3:0] en;
        logic [4:0] bid;
    } vec_t;

    localparam int NV = 32;
    vec_t tv [NV];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic d,
                                input logic [4:0] b2, input logic [3:0] en, input logic [4:0] bid);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.b2 = b2; v.en = en; v.bid = bid;
        return v;
    endfunction

    function automatic logic [3:0] en_now();
        return {bus.buffer_en3, bus.buffer_en2, bus.buffer_en1, bus.buffer_en0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_in = 4'b0000;
        bus.done_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_timeout(input bit with_done);
        logic [3:0] exp_en;
        do_reset();
        bus.req_in = 4'b0001;
        for (int e = 1; e <= 12; e++) begin
            if (with_done) bus.done_in = (e == 11);
            @(negedge clk);
            exp_en = ((e >= 2 && e <= 10) || e == 12) ? 4'b0001 : 4'b0000;
            chk($sformatf("to%0d_en_e%0d", with_done, e), en_now(), exp_en);
            chk($sformatf("to%0d_pulse_e%0d", with_done, e), bus.timeout_out,
                (!with_done && e == 11) ? 1 : 0);
        end
        bus.done_in = 1'b0;
        bus.req_in = 4'b0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_in = 4'b0000;
        bus.done_in = 1'b0;
        bus.busid_in0 = 5'h03;
        bus.busid_in1 = 5'h11;
        bus.busid_in2 = 5'h0A;
        bus.busid_in3 = 5'h1C;

        //            rst  req      done b2     en       busid
        tv[0]  = mk(0, 4'b0001, 0, 5'h0A, 4'b0000, 5'h00);
        tv[1]  = mk(0, 4'b0001, 0, 5'h0A, 4'b0001, 5'h03);
        tv[2]  = mk(0, 4'b0001, 1, 5'h0A, 4'b0001, 5'h03);
        tv[3]  = mk(0, 4'b0000, 1, 5'h0A, 4'b0000, 5'h03);
        tv[4]  = mk(0, 4'b0000, 0, 5'h0A, 4'b0000, 5'h03);
        tv[5]  = mk(1, 4'b0000, 0, 5'h0A, 4'b0000, 5'h00);
        tv[6]  = mk(0, 4'b1111, 0, 5'h0A, 4'b0000, 5'h00);
        tv[7]  = mk(0, 4'b1111, 0, 5'h0A, 4'b0001, 5'h03);
        tv[8]  = mk(0, 4'b1111, 0, 5'h0A, 4'b0001, 5'h03);
        tv[9]  = mk(0, 4'b1111, 1, 5'h0A, 4'b0000, 5'h03);
        tv[10] = mk(0, 4'b1111, 0, 5'h0A, 4'b0010, 5'h11);
        tv[11] = mk(0, 4'b1111, 0, 5'h0A, 4'b0010, 5'h11);
        tv[12] = mk(0, 4'b1111, 1, 5'h0A, 4'b0000, 5'h11);
        tv[13] = mk(0, 4'b1111, 0, 5'h0A, 4'b0100, 5'h0A);
        tv[14] = mk(0, 4'b1111, 0, 5'h0A, 4'b0100, 5'h0A);
        tv[15] = mk(0, 4'b1111, 1, 5'h0A, 4'b0000, 5'h0A);
        tv[16] = mk(0, 4'b1111, 0, 5'h0A, 4'b1000, 5'h1C);
        tv[17] = mk(0, 4'b1111, 0, 5'h0A, 4'b1000, 5'h1C);
        tv[18] = mk(0, 4'b1111, 1, 5'h0A, 4'b0000, 5'h1C);
        tv[19] = mk(0, 4'b1111, 0, 5'h0A, 4'b0001, 5'h03);
        tv[20] = mk(0, 4'b1111, 0, 5'h0A, 4'b0001, 5'h03);
        tv[21] = mk(0, 4'b0000, 1, 5'h0A, 4'b0000, 5'h03);
        tv[22] = mk(0, 4'b0000, 0, 5'h0A, 4'b0000, 5'h03);
        tv[23] = mk(0, 4'b0100, 0, 5'h0A, 4'b0000, 5'h03);
        tv[24] = mk(0, 4'b0100, 0, 5'h0A, 4'b0100, 5'h0A);
        tv[25] = mk(0, 4'b0101, 0, 5'h15, 4'b0100, 5'h0A);
        tv[26] = mk(0, 4'b0101, 0, 5'h15, 4'b0100, 5'h0A);
        tv[27] = mk(0, 4'b0001, 0, 5'h15, 4'b0100, 5'h0A);
        tv[28] = mk(0, 4'b0001, 0, 5'h15, 4'b0000, 5'h0A);
        tv[29] = mk(0, 4'b0001, 0, 5'h15, 4'b0001, 5'h03);
        tv[30] = mk(0, 4'b0000, 1, 5'h15, 4'b0001, 5'h03);
        tv[31] = mk(0, 4'b0000, 0, 5'h15, 4'b0000, 5'h03);

        // Reset state while rst is still held.
        @(negedge clk);
        @(negedge clk);
        chk("rst_en", en_now(), 4'b0000);
        chk("rst_busid", bus.busid_out, 5'h00);
        chk("rst_busy", bus.busy_out, 1'b0);
        chk("rst_timeout", bus.timeout_out, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            rst = tv[i].rst;
            bus.req_in = tv[i].req;
            bus.done_in = tv[i].done;
            bus.busid_in2 = tv[i].b2;
            @(negedge clk);
            chk($sformatf("v%0d_en", i), en_now(), tv[i].en);
            chk($sformatf("v%0d_busid", i), bus.busid_out, tv[i].bid);
            chk($sformatf("v%0d_busy", i), bus.busy_out, (tv[i].en != 4'b0000) ? 1 : 0);
            chk($sformatf("v%0d_timeout", i), bus.timeout_out, 1'b0);
        end
        rst = 1'b0;
        bus.done_in = 1'b0;
        bus.req_in = 4'b0000;

`ifdef BUSID_ARB_TIMEOUT_EN
        run_timeout(1'b0);
        run_timeout(1'b1);
`else
        begin
            bit held;
            bit seen_to;
            do_reset();
            bus.req_in = 4'b0001;
            held = 1'b1;
            seen_to = 1'b0;
            for (int e = 1; e <= 120; e++) begin
                @(negedge clk);
                if (e >= 2 && en_now() != 4'b0001) held = 1'b0;
                if (bus.timeout_out) seen_to = 1'b1;
            end
            chk("hold_persists", held, 1'b1);
            chk("no_timeout_pulse", seen_to, 1'b0);
            bus.done_in = 1'b1;
            @(negedge clk);
            chk("hold_done_release", en_now(), 4'b0000);
            bus.done_in = 1'b0;
            bus.req_in = 4'b0000;
        end
`endif

        // Reset in the middle of a HOLD on channel 2, then channel 0 must win first.
        do_reset();
        bus.req_in = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("mid_grant_en", en_now(), 4'b0100);
        @(negedge clk);
        chk("mid_hold_busy", bus.busy_out, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", en_now(), 4'b0000);
        chk("async_rst_busid", bus.busid_out, 5'h00);
        chk("async_rst_busy", bus.busy_out, 1'b0);
        chk("async_rst_timeout", bus.timeout_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_in = 4'b1111;
        @(negedge clk);
        chk("post_rst_idle_en", en_now(), 4'b0000);
        @(negedge clk);
        chk("post_rst_first_en", en_now(), 4'b0001);
        chk("post_rst_first_busid", bus.busid_out, 5'h03);
        bus.req_in = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
